// File: rtl/e203_sysmem_icb_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : e203_sysmem_icb_ram_if
//  Description : ICB command/response bundle between the subsystem sysmem
//                master port and the on-chip RAM slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface e203_sysmem_icb_ram_if #(
    parameter int ADDR_WIDTH = 32
) ();
    // Command channel
    logic                  icb_cmd_valid;
    logic                  icb_cmd_ready;
    logic [ADDR_WIDTH-1:0] icb_cmd_addr;
    logic                  icb_cmd_read;
    logic [31:0]           icb_cmd_wdata;
    logic [3:0]            icb_cmd_wmask;
    // Response channel
    logic                  icb_rsp_valid;
    logic                  icb_rsp_ready;
    logic                  icb_rsp_err;
    logic [31:0]           icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/e203_sysmem_icb_ram.sv
`default_nettype none
// ============================================================================
//  Module      : e203_sysmem_icb_ram
//  Description : ICB slave terminating the sysmem port with a word-addressed
//                on-chip RAM. Byte-masked writes, combinational reads, and a
//                2-entry in-order response FIFO for single-cycle throughput.
//                Optional feature macro: E203_SYSMEM_ADDR_CHK_EN enables the
//                upper-address range check (err=1 on out-of-region access).
//  Revision    : 1.0 - initial release
// ============================================================================
module e203_sysmem_icb_ram #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    e203_sysmem_icb_ram_if.slave    icb
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // RAM array (not reset) and response FIFO storage ({err, rdata})
    logic [31:0] mem_q  [0:DEPTH_WORDS-1];
    logic [32:0] fifo_q [0:1];

    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic [1:0] cnt_q,  cnt_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             cmd_accept;
    logic             cmd_write;
    logic             rsp_pop;
    logic             addr_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [32:0]      push_entry;
    logic [32:0]      head_entry;
    logic             unused_addr_bits;

    assign word_idx = icb.icb_cmd_addr[IDX_W+1:2];

`ifdef E203_SYSMEM_ADDR_CHK_EN
    // Region check: everything above the RAM window must match the base.
    assign addr_err = (icb.icb_cmd_addr[ADDR_WIDTH-1:IDX_W+2] !=
                       BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]);
    assign unused_addr_bits = ^icb.icb_cmd_addr[1:0];
`else
    // No range check: upper bits alias the RAM window, never an error.
    assign addr_err = 1'b0;
    assign unused_addr_bits = ^{icb.icb_cmd_addr[1:0],
                                icb.icb_cmd_addr[ADDR_WIDTH-1:IDX_W+2],
                                BASE_ADDR};
`endif

    // Ready depends only on registered occupancy: a full FIFO rejects even
    // when it is popped in the same cycle, so no rsp->cmd combinational path.
    assign fifo_full  = (cnt_q == 2'd2);
    assign fifo_empty = (cnt_q == 2'd0);

    assign icb.icb_cmd_ready = !fifo_full;
    assign cmd_accept        = icb.icb_cmd_valid & !fifo_full;
    assign cmd_write         = cmd_accept & !icb.icb_cmd_read & !addr_err;
    assign rsp_pop           = !fifo_empty & icb.icb_rsp_ready;

    // Read data is 0 for writes and errored commands.
    assign rd_word    = mem_q[word_idx];
    assign push_entry = {addr_err,
                         (icb.icb_cmd_read & !addr_err) ? rd_word : 32'h0};

    // Head entry drives the response; gated so outputs are 0 when empty.
    assign head_entry        = fifo_q[rptr_q];
    assign icb.icb_rsp_valid = !fifo_empty;
    assign icb.icb_rsp_err   = !fifo_empty & head_entry[32];
    assign icb.icb_rsp_rdata = fifo_empty ? 32'h0 : head_entry[31:0];

    // Next-state for FIFO pointers and occupancy count.
    always_comb begin
        wptr_d = wptr_q ^ cmd_accept;
        rptr_d = rptr_q ^ rsp_pop;
        cnt_d  = cnt_q;
        case ({cmd_accept, rsp_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO control registers; reset discards any buffered responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO payload storage, written on every accepted command.
    always_ff @(posedge clk) begin
        if (cmd_accept) begin
            fifo_q[wptr_q] <= push_entry;
        end
    end

    // Byte-masked RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (cmd_write && icb.icb_cmd_wmask[b]) begin
                mem_q[word_idx][8*b +: 8] <= icb.icb_cmd_wdata[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire
